peblock_ctrl: RTL and testbench

Initiator-side controller for the 2x4 PE multiply block. It accepts one job from an upstream stream as eight (A, B) operand pairs and writes them into the PE block over its valid/address/data load port. It then pulses start, waits for all eight PE done flags, and acknowledges the 1024-bit result. Finally it streams the result downstream as eight 128-bit words with a valid/ready handshake.

---
 rtl/pe_pkg.sv | 20 ++
 rtl/tempc_serializer.sv | 71 +++++++
 rtl/peblock_ctrl.sv | 156 +++++++++++++++
 tb/tb_peblock_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and state encoding for the PE block initiator controller.
package pe_pkg;

  localparam int PE_NPE = 8;
  localparam int PE_AW  = 64;
  localparam int PE_CW  = 128;

  // Every PE has raised its done flag.
  localparam logic [PE_NPE-1:0] ALL_DONE = 8'hFF;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_ACK,
    ST_RELEASE,
    ST_OUT
  } state_e;

endpackage

// File: rtl/tempc_serializer.sv
// Holds the captured PE result and streams it out as NPE words, lowest word
// first, over a valid/ready handshake. done_o pulses when the last word is taken.
module tempc_serializer
  import pe_pkg::*;
#(
  parameter int CW  = PE_CW,
  parameter int NPE = PE_NPE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [NPE*CW-1:0] tempc_i,
  input  logic              start_i,
  output logic              done_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [CW-1:0]     m_data_o,
  output logic [2:0]        m_idx_o,
  output logic              m_last_o
);

  localparam logic [2:0] LAST_IDX = 3'(NPE - 1);

  logic [NPE*CW-1:0] res_q, res_d;
  logic [2:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              fire;

  assign fire = valid_q & m_ready_i;

  // Word index and valid advance only on an accepted word; start rewinds to word 0.
  always_comb begin
    res_d   = res_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load_i) begin
      res_d = tempc_i;
    end
    if (start_i) begin
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (fire) begin
      if (idx_q == LAST_IDX) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  // Result buffer and handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_idx_o   = idx_q;
  assign m_data_o  = res_q[int'(idx_q)*CW +: CW];
  assign m_last_o  = valid_q & (idx_q == LAST_IDX);
  assign done_o    = fire & (idx_q == LAST_IDX);

endmodule

// File: rtl/peblock_ctrl.sv
// Initiator for the 2x4 PE multiply block: loads eight operand pairs, starts
// the block, waits for every PE to finish, acknowledges, then streams the result.
module peblock_ctrl
  import pe_pkg::*;
#(
  parameter int AW  = PE_AW,
  parameter int CW  = PE_CW,
  parameter int NPE = PE_NPE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [AW-1:0]     s_a,
  input  logic [AW-1:0]     s_b,
  output logic              pe_valid,
  output logic [2:0]        pe_addra,
  output logic [AW-1:0]     pe_inpa,
  output logic [2:0]        pe_addrb,
  output logic [AW-1:0]     pe_inpb,
  output logic              pe_start,
  input  logic [NPE-1:0]    pe_done,
  input  logic [NPE*CW-1:0] pe_tempc,
  output logic              pe_tempc_ack,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW-1:0]     m_data,
  output logic [2:0]        m_idx,
  output logic              m_last,
  output logic              busy
);

  localparam logic [3:0] SLOTS = 4'(NPE);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          start_q, start_d;
  logic          ack_q, ack_d;
  logic          ld_valid_q;
  logic [2:0]    ld_addr_q;
  logic [AW-1:0] ld_a_q, ld_b_q;
  logic          accept;
  logic          cap_load;
  logic          ser_start;
  logic          ser_done;

  // s_ready_q is only ever high in LOAD with free slots, so this is a LOAD beat.
  assign accept = s_valid & s_ready_q;

  // Next-state logic; registered strobes are derived from the upcoming state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_load  = 1'b0;
    ser_start = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
        end
        // Count reaches SLOTS in the cycle the last pe_valid is on the bus.
        if (cnt_q == SLOTS) begin
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (pe_done == ALL_DONE) begin
          cap_load = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: state_d = ST_RELEASE;
      ST_RELEASE: begin
        // Wait for done to drop so a stale all-done is never mistaken for the next job.
        if (pe_done != ALL_DONE) begin
          ser_start = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (ser_done) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    s_ready_d = (state_d == ST_LOAD) && (cnt_d < SLOTS);
    start_d   = (state_d == ST_START);
    ack_d     = (state_d == ST_ACK);
  end

  // Control state and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
    end
  end

  // Registered load port: each accepted beat writes slot cnt_q one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid_q <= 1'b0;
      ld_addr_q  <= '0;
      ld_a_q     <= '0;
      ld_b_q     <= '0;
    end else begin
      ld_valid_q <= accept;
      if (accept) begin
        ld_addr_q <= cnt_q[2:0];
        ld_a_q    <= s_a;
        ld_b_q    <= s_b;
      end
    end
  end

  tempc_serializer #(
    .CW  (CW),
    .NPE (NPE)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cap_load),
    .tempc_i   (pe_tempc),
    .start_i   (ser_start),
    .done_o    (ser_done),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_idx_o   (m_idx),
    .m_last_o  (m_last)
  );

  assign s_ready      = s_ready_q;
  assign pe_valid     = ld_valid_q;
  assign pe_addra     = ld_addr_q;
  assign pe_addrb     = ld_addr_q;
  assign pe_inpa      = ld_a_q;
  assign pe_inpb      = ld_b_q;
  assign pe_start     = start_q;
  assign pe_tempc_ack = ack_q;
  assign busy         = !((state_q == ST_LOAD) && (cnt_q == 4'd0));

endmodule

// File: tb/tb_peblock_ctrl.sv
// Scoreboard bench for peblock_ctrl: drivers push expected PE loads and result
// words into queues; independent monitors pop and compare as the DUT emits them.
module tb_peblock_ctrl;
  import pe_pkg::*;

  localparam int AW  = 64;
  localparam int CW  = 128;
  localparam int NPE = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_ready;
  logic [AW-1:0]     s_a, s_b;
  logic              pe_valid;
  logic [2:0]        pe_addra, pe_addrb;
  logic [AW-1:0]     pe_inpa, pe_inpb;
  logic              pe_start;
  logic [NPE-1:0]    pe_done;
  logic [NPE*CW-1:0] pe_tempc;
  logic              pe_tempc_ack;
  logic              m_valid, m_ready;
  logic [CW-1:0]     m_data;
  logic [2:0]        m_idx;
  logic              m_last;
  logic              busy;

  peblock_ctrl #(.AW(AW), .CW(CW), .NPE(NPE)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .pe_valid(pe_valid), .pe_addra(pe_addra), .pe_inpa(pe_inpa),
    .pe_addrb(pe_addrb), .pe_inpb(pe_inpb), .pe_start(pe_start),
    .pe_done(pe_done), .pe_tempc(pe_tempc), .pe_tempc_ack(pe_tempc_ack),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]    addr;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } ld_t;

  typedef struct {
    logic [2:0]    idx;
    logic [CW-1:0] data;
    logic          last;
  } ow_t;

  ld_t ld_q[$];
  ow_t out_q[$];

  int checks = 0;
  int fails  = 0;
  int acc_cyc = 0;
  int first_acc = 0;
  int last_acc = 0;
  logic [NPE*CW-1:0] exp_tempc;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [NPE*CW-1:0] mk_tempc(input int job);
    logic [NPE*CW-1:0] t;
    t = '0;
    for (int i = 0; i < NPE; i++)
      t[i*CW +: CW] = {32'(job), 32'hFEED0000 + 32'(i), 64'(job * 256 + i * 17 + 1)};
    return t;
  endfunction

  function automatic logic out_or();
    return |{s_ready, pe_valid, pe_addra, pe_addrb, pe_inpa, pe_inpb, pe_start,
             pe_tempc_ack, m_valid, m_data, m_idx, m_last, busy};
  endfunction

  // Load-port monitor
  initial begin : mon_load
    ld_t e;
    forever begin
      @(negedge clk);
      #2;
      if (pe_valid) begin
        chk("valid_not_with_start", pe_start, 1'b0);
        if (ld_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_pe_valid actual addr=%0d required=none", pe_addra);
        end else begin
          e = ld_q.pop_front();
          chk("pe_addra", pe_addra, e.addr);
          chk("pe_addrb", pe_addrb, e.addr);
          chk("pe_inpa", pe_inpa, e.a);
          chk("pe_inpb", pe_inpb, e.b);
        end
      end
    end
  end

  // Result-stream monitor
  initial begin : mon_out
    ow_t e;
    forever begin
      @(negedge clk);
      #2;
      if (m_valid && m_ready) begin
        if (out_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_word actual idx=%0d required=none", m_idx);
        end else begin
          e = out_q.pop_front();
          chk("m_idx", m_idx, e.idx);
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
          if (e.idx == 3'd0) first_acc = cyc;
          if (e.idx == 3'd7) last_acc = cyc;
        end
      end
    end
  end

  task automatic load_job(input int job, input bit gapped, input int nbeats, input bit junk);
    int n = 0;
    int g = 0;
    bit ph = 1'b0;
    for (int i = 0; i < nbeats; i++)
      ld_q.push_back('{3'(i), 64'(job * 1000 + i + 1), 64'(job * 1000 + 16 + i)});
    while (n < nbeats && g < 200) begin
      tick();
      g++;
      ph = ~ph;
      s_valid = gapped ? ph : 1'b1;
      s_a = 64'(job * 1000 + n + 1);
      s_b = 64'(job * 1000 + 16 + n);
      if (s_valid && s_ready) begin
        acc_cyc = cyc;
        n++;
      end
    end
    chk("beats_accepted", n, nbeats);
    if (nbeats == NPE) begin
      tick();
      if (junk) begin
        s_a = 64'hDEAD_BEEF_DEAD_BEEF;
        s_b = 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        s_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_start();
    int g = 0;
    while (!pe_start && g < 50) begin
      tick();
      g++;
    end
    chk("start_seen", pe_start, 1'b1);
    chk("start_latency", cyc - acc_cyc, 2);
    chk("all_loads_seen", ld_q.size(), 0);
    tick();
    chk("start_one_cycle", pe_start, 1'b0);
  endtask

  task automatic complete(input int job, input int dly, input bit partial, input int hold);
    int bad = 0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    pe_tempc = mk_tempc(job + 50);
    repeat (dly) tick();
    if (partial) begin
      pe_done = 8'h7F;
      repeat (50) begin
        tick();
        if (pe_tempc_ack || m_valid) bad++;
      end
      chk("partial_no_ack", bad, 0);
    end
    pe_done   = 8'hFF;
    exp_tempc = mk_tempc(job);
    pe_tempc  = exp_tempc;
    for (int i = 0; i < NPE; i++)
      out_q.push_back('{3'(i), exp_tempc[i*CW +: CW], (i == NPE - 1)});
    tick();
    chk("ack_pulse", pe_tempc_ack, 1'b1);
    pe_tempc = mk_tempc(job + 77);
    if (hold == 0) begin
      pe_done = '0;
      tick();
      chk("ack_one_cycle", pe_tempc_ack, 1'b0);
      chk("release_no_valid", m_valid, 1'b0);
    end else begin
      bad = 0;
      repeat (hold) begin
        tick();
        if (pe_tempc_ack || m_valid) bad++;
      end
      chk("stale_hold", bad, 0);
      chk("stale_busy", busy, 1'b1);
      pe_done = '0;
    end
    tick();
    chk("mvalid_rise", m_valid, 1'b1);
  endtask

  task automatic drain(input bit bp);
    int g = 0;
    bit stalled = 1'b0;
    while (out_q.size() != 0 && g < 300) begin
      tick();
      g++;
      if (bp && !stalled && m_valid && m_idx == 3'd3) begin
        m_ready = 1'b0;
        chk("bp_word3", m_data, exp_tempc[3*CW +: CW]);
        repeat (5) begin
          tick();
          chk("bp_valid", m_valid, 1'b1);
          chk("bp_idx", m_idx, 3'd3);
          chk("bp_data", m_data, exp_tempc[3*CW +: CW]);
          chk("bp_sready", s_ready, 1'b0);
        end
        m_ready = 1'b1;
        stalled = 1'b1;
      end
    end
    chk("drain_done", out_q.size(), 0);
    chk("sready_after_out", s_ready, 1'b1);
    chk("busy_after_out", busy, 1'b0);
    chk("mvalid_after_out", m_valid, 1'b0);
    if (!bp) chk("throughput", last_acc - first_acc, 7);
  endtask

  task automatic do_reset();
    tick();
    rst     = 1'b1;
    s_valid = 1'b0;
    pe_done = '0;
    m_ready = 1'b0;
    #1;
    chk("rst_outputs_zero", out_or(), 1'b0);
    ld_q.delete();
    out_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("sready_post_rst", s_ready, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_a      = '0;
    s_b      = '0;
    pe_done  = '0;
    pe_tempc = '0;
    m_ready  = 1'b0;
    #3;
    chk("por_outputs_zero", out_or(), 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("sready_after_por", s_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);

    // Nominal job, s_valid left high with junk after the load.
    load_job(1, 1'b0, 8, 1'b1);
    wait_start();
    complete(1, 20, 1'b0, 0);
    drain(1'b0);

    // Gapped input.
    load_job(2, 1'b1, 8, 1'b0);
    wait_start();
    complete(2, 5, 1'b0, 0);
    drain(1'b0);

    // Partial done, tempc changes after capture.
    load_job(3, 1'b0, 8, 1'b0);
    wait_start();
    complete(3, 3, 1'b1, 0);
    drain(1'b0);

    // Stale done held after the ack, then a second job.
    load_job(4, 1'b0, 8, 1'b0);
    wait_start();
    complete(4, 2, 1'b0, 10);
    drain(1'b0);
    load_job(5, 1'b0, 8, 1'b0);
    wait_start();
    complete(5, 4, 1'b0, 0);
    drain(1'b0);

    // Backpressure on word 3.
    load_job(6, 1'b0, 8, 1'b0);
    wait_start();
    complete(6, 4, 1'b0, 0);
    drain(1'b1);

    // Reset after beat 4, reset in WAIT, then a clean job.
    load_job(7, 1'b0, 5, 1'b0);
    do_reset();
    load_job(8, 1'b0, 8, 1'b0);
    wait_start();
    repeat (3) tick();
    chk("wait_busy", busy, 1'b1);
    do_reset();
    load_job(9, 1'b0, 8, 1'b0);
    wait_start();
    complete(9, 20, 1'b0, 0);
    drain(1'b0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
